// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: MIPS-subset decode with bypassed regfile, control decode and a handshaked ID/EX register
module decode_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ex_rs_data,
  output logic [XLEN-1:0]  ex_rt_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_dest,
  output logic [3:0]       ex_alu_ctrl,
  output logic [6:0]       ex_ctrl,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NR = 6'(NREGS);
  logic [XLEN-1:0] rf [NREGS];
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic is_r, is_lw, is_sw, is_beq, is_addi, f_ok, uses_rt, illegal, reg_write;
  logic rs_ok, rt_ok, wb_ok, adv, haz;
  logic [3:0] f_alu, alu;
  logic [4:0] dest;
  logic [XLEN-1:0] rs_val, rt_val;
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign rs_ok = rs != 5'd0 && {1'b0, rs} < NR;
  assign rt_ok = rt != 5'd0 && {1'b0, rt} < NR;
  assign wb_ok = wb_we && wb_addr != 5'd0 && {1'b0, wb_addr} < NR;
  // Operand read: out-of-range and r0 read as zero, a same-cycle write-back is forwarded
  always_comb begin
    rs_val = !rs_ok ? '0 : (wb_we && wb_addr == rs) ? wb_data : rf[rs[AW-1:0]];
    rt_val = !rt_ok ? '0 : (wb_we && wb_addr == rt) ? wb_data : rf[rt[AW-1:0]];
  end
  // Main and ALU control decode
  always_comb begin
    is_r      = op == 6'b000000;
    is_lw     = op == 6'b100011;
    is_sw     = op == 6'b101011;
    is_beq    = op == 6'b000100;
    is_addi   = op == 6'b001000;
    f_ok      = funct == 6'h20 || funct == 6'h22 || funct == 6'h24 || funct == 6'h25 || funct == 6'h2A;
    f_alu     = funct == 6'h20 ? 4'b0010 : funct == 6'h22 ? 4'b0110 : funct == 6'h25 ? 4'b0001 :
                funct == 6'h2A ? 4'b0111 : 4'b0000;
    alu       = is_r ? f_alu : is_beq ? 4'b0110 : (is_lw || is_sw || is_addi) ? 4'b0010 : 4'b0000;
    illegal   = !(is_r || is_lw || is_sw || is_beq || is_addi) || (is_r && !f_ok);
    reg_write = (is_r && f_ok) || is_lw || is_addi;
    dest      = is_r ? rd : (is_lw || is_addi) ? rt : 5'd0;
    uses_rt   = is_r || is_sw || is_beq;
  end
  // Handshake and load-use hazard against the load sitting in ID/EX
  always_comb begin
    adv      = out_ready || !out_valid;
    haz      = out_valid && ex_ctrl[4] && ex_dest != 5'd0 && (ex_dest == rs || (uses_rt && ex_dest == rt));
    in_ready = adv && !haz && !flush;
  end
  // Register file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    else if (wb_ok) rf[wb_addr[AW-1:0]] <= wb_data;
  end
  // ID/EX register: flush beats bubble beats load; hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_dest     <= '0;
      ex_alu_ctrl <= '0;
      ex_ctrl     <= '0;
      stall_cnt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv && haz) begin
      out_valid <= 1'b0;
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end else if (adv && in_valid) begin
      out_valid   <= 1'b1;
      ex_rs_data  <= rs_val;
      ex_rt_data  <= rt_val;
      ex_imm      <= XLEN'($signed(instr[15:0]));
      ex_dest     <= dest;
      ex_alu_ctrl <= alu;
      ex_ctrl     <= {is_beq, is_lw, is_lw, is_sw, reg_write, is_lw || is_sw || is_addi, illegal};
    end else if (adv) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed checks of decode, bypass, hazard bubble, backpressure and flush
module tb_decode_stage_pipe;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, wb_we = 0, out_ready = 1;
  logic [31:0] instr = 0, wb_data = 0;
  logic [4:0] wb_addr = 0;
  logic in_ready, out_valid, s_in_ready, s_out_valid;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [15:0] s_rs_data, s_rt_data, s_imm, stall_cnt, s_stall_cnt;
  logic [4:0] ex_dest, s_dest;
  logic [3:0] ex_alu_ctrl, s_alu;
  logic [6:0] ex_ctrl, s_ctrl;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  decode_stage_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_dest(ex_dest),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt));
  decode_stage_pipe #(.XLEN(16), .NREGS(8)) u_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .instr(instr), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data[15:0]), .out_valid(s_out_valid), .out_ready(out_ready),
    .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm), .ex_dest(s_dest),
    .ex_alu_ctrl(s_alu), .ex_ctrl(s_ctrl), .stall_cnt(s_stall_cnt));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_dest", ex_dest, 0);
    rst = 0;
    wb_we = 1; wb_addr = 5; wb_data = 32'hAA;
    tick;
    wb_we = 0;
    instr = 32'h00A51820; in_valid = 1;
    #1 chk("add_in_ready", in_ready, 1);
    tick;
    chk("add_valid", out_valid, 1);
    chk("add_rs", ex_rs_data, 32'hAA);
    chk("add_rt", ex_rt_data, 32'hAA);
    chk("add_dest", ex_dest, 3);
    chk("add_alu", ex_alu_ctrl, 4'b0010);
    chk("add_ctrl", ex_ctrl, 7'b0000100);
    instr = 32'h8C48FFFC;
    tick;
    chk("lw_dest", ex_dest, 8);
    chk("lw_ctrl", ex_ctrl, 7'b0110110);
    chk("lw_imm", ex_imm, 32'hFFFFFFFC);
    chk("lw_alu", ex_alu_ctrl, 4'b0010);
    instr = 32'h01014822;
    #1 chk("hz_in_ready", in_ready, 0);
    tick;
    chk("hz_bubble", out_valid, 0);
    chk("hz_stall", stall_cnt, 1);
    chk("hz_in_ready2", in_ready, 1);
    tick;
    chk("sub_valid", out_valid, 1);
    chk("sub_alu", ex_alu_ctrl, 4'b0110);
    chk("sub_dest", ex_dest, 9);
    chk("sub_stall", stall_cnt, 1);
    instr = 32'h20800005; wb_we = 1; wb_addr = 4; wb_data = 32'h1234;
    tick;
    chk("byp_rs", ex_rs_data, 32'h1234);
    chk("byp_imm", ex_imm, 5);
    chk("byp_dest", ex_dest, 0);
    chk("byp_ctrl", ex_ctrl, 7'b0000110);
    wb_addr = 0; wb_data = 32'hDEAD; in_valid = 0;
    tick;
    instr = 32'h00000820; in_valid = 1;
    tick;
    wb_we = 0;
    chk("r0_rs", ex_rs_data, 0);
    chk("r0_rt", ex_rt_data, 0);
    chk("r0_dest", ex_dest, 1);
    out_ready = 0; instr = 32'h00A45025;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      tick;
      chk("bp_valid", out_valid, 1);
      chk("bp_dest", ex_dest, 1);
      chk("bp_alu", ex_alu_ctrl, 4'b0010);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    tick;
    chk("or_dest", ex_dest, 10);
    chk("or_rs", ex_rs_data, 32'hAA);
    chk("or_rt", ex_rt_data, 32'h1234);
    chk("or_alu", ex_alu_ctrl, 4'b0001);
    instr = 32'h8C48FFFC;
    tick;
    instr = 32'h01014822; flush = 1;
    #1 chk("fl_in_ready", in_ready, 0);
    tick;
    flush = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_stall", stall_cnt, 1);
    tick;
    chk("fl_sub_valid", out_valid, 1);
    chk("fl_sub_dest", ex_dest, 9);
    instr = 32'h00A4102A;
    tick;
    chk("slt_alu", ex_alu_ctrl, 4'b0111);
    chk("slt_ctrl", ex_ctrl, 7'b0000100);
    instr = 32'h10A4FFFF;
    tick;
    chk("beq_ctrl", ex_ctrl, 7'b1000000);
    chk("beq_alu", ex_alu_ctrl, 4'b0110);
    chk("beq_dest", ex_dest, 0);
    instr = 32'hFC000000;
    tick;
    chk("ill_op_ctrl", ex_ctrl, 7'b0000001);
    chk("ill_op_alu", ex_alu_ctrl, 0);
    chk("ill_op_dest", ex_dest, 0);
    instr = 32'h0000183F;
    tick;
    chk("ill_fn_ctrl", ex_ctrl, 7'b0000001);
    chk("ill_fn_alu", ex_alu_ctrl, 0);
    wb_we = 1; wb_addr = 12; wb_data = 32'h5555; in_valid = 0;
    tick;
    wb_we = 0; instr = 32'h01800820; in_valid = 1;
    tick;
    chk("big_r12", ex_rs_data, 32'h5555);
    chk("small_r12", s_rs_data, 0);
    instr = 32'h20018000;
    tick;
    chk("big_imm", ex_imm, 32'hFFFF8000);
    chk("small_imm", s_imm, 16'h8000);
    chk("small_valid", s_out_valid, 1);
    #2 rst = 1;
    #1 chk("arst_valid", out_valid, 0);
    chk("arst_imm", ex_imm, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised MIPS-subset decode stage that replaces the single-cycle decode block. It contains a reset-cleared register file with write-back bypass, the main control decoder, the ALU-control decoder, and a registered ID/EX output stage with a valid/ready handshake. It also detects load-use hazards, inserting one bubble per hazard, and supports a pipeline flush. It sits between the IF/ID register and the execute stage.

Parameters:
XLEN, 32, datapath width; sign-extension target; legal range 16..64
NREGS, 32, number of architectural registers; legal range 2..32; register 0 is hardwired to zero
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  instr is valid
in_ready  out  1  instr is accepted this cycle when in_valid && in_ready
instr  in  32  MIPS instruction word
flush  in  1  discard the ID/EX contents and any instruction being accepted
wb_we  in  1  write-back enable
wb_addr  in  5  write-back register index
wb_data  in  XLEN  write-back data
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  execute stage consumes ID/EX this cycle
ex_rs_data  out  XLEN  rs operand
ex_rt_data  out  XLEN  rt operand
ex_imm  out  XLEN  sign-extended instr[15:0]
ex_dest  out  5  destination register (rd for R-type, rt for LW/ADDI, 0 otherwise)
ex_alu_ctrl  out  4  ALU operation code
ex_ctrl  out  7  {branch, mem_to_reg, mem_read, mem_write, reg_write, alu_src, illegal}
stall_cnt  out  CNT_W  count of hazard bubbles inserted, saturating

Behaviour:
- Reset, asynchronous: all registers cleared to 0; out_valid=0, all ex_* outputs =0, stall_cnt=0. Reset asserted mid-operation drops everything in flight.
- Register file: NREGS x XLEN, written on the clock edge when wb_we && wb_addr!=0 && wb_addr<NREGS.
  - Reads of index 0 or index >= NREGS return 0.
  - Bypass: when wb_we && wb_addr==source index && wb_addr!=0, the read returns wb_data in the same cycle.
- Decode by opcode (instr[31:26]):
  - R-type 000000: ctrl reg_write=1, ALUOp=10.
  - LW 100011: alu_src, mem_read, mem_to_reg, reg_write =1; ALUOp=00.
  - SW 101011: alu_src, mem_write =1; ALUOp=00.
  - BEQ 000100: branch=1; ALUOp=01.
  - ADDI 001000: alu_src, reg_write =1; ALUOp=00.
  - Any other opcode: all ctrl bits =0 except illegal=1; ex_dest=0.
- ALU control:
  - ALUOp 00 -> 0010.
  - ALUOp 01 -> 0110.
  - ALUOp 10 by funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111.
  - Unknown funct -> ex_alu_ctrl=0000, illegal=1, reg_write=0.
- Advance condition: adv = out_ready || !out_valid.
- Load-use hazard: haz = out_valid && ex_ctrl.mem_read && ex_dest!=0 && (ex_dest==rs || (uses_rt && ex_dest==rt)). uses_rt is 1 for R-type, SW and BEQ.
- in_ready = adv && !haz && !flush.
- On each clock edge, with priority in this order:
  1. flush: out_valid<=0. The input is not accepted. ex_* fields may hold stale values.
  2. adv && haz: out_valid<=0 (bubble). The input instruction is held upstream. stall_cnt increments, saturating at 2^CNT_W-1.
  3. adv && in_valid: load ID/EX with the decoded fields; out_valid<=1.
  4. adv && !in_valid: out_valid<=0.
  5. Otherwise (!adv): hold all ID/EX contents.
- Decode-to-output latency is 1 cycle. A load-use pair costs exactly 1 bubble, because the bubble clears out_valid and the hazard with it.
- A write-back in the same cycle as acceptance is visible to the accepted instruction through the bypass.

Test Plan:
- Reset, then write 0x0000_00AA to r5 via wb; accept `add r3,r5,r5` (0x00A51820) -> next cycle out_valid=1, ex_rs_data=ex_rt_data=0xAA, ex_dest=3, ex_alu_ctrl=0010, ex_ctrl reg_write=1.
- Accept `lw r8,-4(r2)` (0x8C48FFFC), then `sub r9,r8,r1` presented next cycle with out_ready=1 -> in_ready=0 for 1 cycle, out_valid=0 bubble, stall_cnt=1; sub accepted the following cycle with ex_alu_ctrl=0110.
- Bypass and r0: wb_we=1, wb_addr=4, wb_data=0x1234 while accepting `addi r0,r4,5` (0x20800005) -> ex_rs_data=0x1234, ex_imm=5; separately, a wb write to r0 followed by a read of r0 returns 0.
- Backpressure: out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0 and ex_* stable; release -> the next instruction loads.
- Flush asserted together with in_valid=1 and a pending hazard -> in_ready=0, out_valid=0 next cycle, stall_cnt unchanged.
- Opcode 0x3F and R-type funct 0x3F -> illegal=1, reg_write=0, ex_alu_ctrl=0000; with NREGS=8, XLEN=16, a read of r12 returns 0 and ex_imm of 0x8000 equals 0x8000.
